// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors for a 50 MHz clock, parity encodings,
// and the transmit state enum that the receiver will also use.
package uart_pkg;

  localparam int unsigned BAUD_9600   = 5208;
  localparam int unsigned BAUD_19200  = 2604;
  localparam int unsigned BAUD_38400  = 1302;
  localparam int unsigned BAUD_57600  = 868;
  localparam int unsigned BAUD_115200 = 434;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  // Unused codes fall back to the slowest rate.
  function automatic int unsigned baud_div(input logic [2:0] sel);
    case (sel)
      3'd1:    return BAUD_19200;
      3'd2:    return BAUD_38400;
      3'd3:    return BAUD_57600;
      3'd4:    return BAUD_115200;
      default: return BAUD_9600;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_param_baud_tick.sv
// Bit-period counter: strobes on the last clock of each bit period and
// restarts from zero whenever it is disabled.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic             last;

  assign last = (cnt == period - DIV_W'(1));
  assign tick = enable && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input, LSB first.
// Optional UART_TX_BREAK_EN adds a send_break input that holds the idle line low.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [2:0]        baud_set,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
`ifdef UART_TX_BREAK_EN
  input  logic              send_break,
`endif
  output logic              rs232_tx,
  output logic              tx_done,
  output logic              uart_state
);

  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_e         state;
  logic [DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]  bit_idx;
  logic [DIV_W-1:0]  period_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic              stop_idx;
  logic              tick;
  logic              accept;

`ifdef UART_TX_BREAK_EN
  logic brk_q;
  logic brk_hold_q;
  // Ready stays low one extra clock after the break is released.
  assign tx_ready = (state == IDLE) && !send_break && !brk_q && !brk_hold_q;
`else
  assign tx_ready = (state == IDLE);
`endif

  assign accept = tx_valid && tx_ready;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state != IDLE),
    .period (period_q),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rs232_tx   <= 1'b1;
      tx_done    <= 1'b0;
      uart_state <= 1'b0;
      shift_q    <= '0;
      bit_idx    <= '0;
      period_q   <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_q      <= 1'b0;
      brk_hold_q <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_q      <= send_break && (state == IDLE);
      brk_hold_q <= brk_q;
`endif
      unique case (state)
        IDLE: begin
          if (accept) begin
            state      <= START;
            rs232_tx   <= 1'b0;
            uart_state <= 1'b1;
            shift_q    <= tx_data;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            stop2_q    <= stop2;
            period_q   <= DIV_W'(baud_div(baud_set));
            par_en_q   <= (parity_mode == PAR_ODD) || (parity_mode == PAR_EVEN);
            par_bit_q  <= (parity_mode == PAR_EVEN) ? ^tx_data : ~^tx_data;
          end else begin
`ifdef UART_TX_BREAK_EN
            rs232_tx <= ~send_break;
`else
            rs232_tx <= 1'b1;
`endif
          end
        end
        START: begin
          if (tick) begin
            state    <= DATA;
            rs232_tx <= shift_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
              if (par_en_q) begin
                state    <= PARITY;
                rs232_tx <= par_bit_q;
              end else begin
                state    <= STOP;
                rs232_tx <= 1'b1;
              end
            end else begin
              bit_idx  <= bit_idx + IDX_W'(1);
              shift_q  <= shift_q >> 1;
              rs232_tx <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state    <= STOP;
            rs232_tx <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop2_q && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              state      <= IDLE;
              uart_state <= 1'b0;
              tx_done    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: table of frames plus back-to-back,
// mid-frame input change and mid-frame reset sequences.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [2:0] baud_set = '0;
  logic [1:0] parity_mode = '0;
  logic       stop2 = 1'b0;
  logic       rs232_tx;
  logic       tx_done;
  logic       uart_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_tx_param #(
    .DATA_W (8),
    .DIV_W  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .baud_set    (baud_set),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .rs232_tx    (rs232_tx),
    .tx_done     (tx_done),
    .uart_state  (uart_state)
  );

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pm;
    logic        s2;
    logic [2:0]  bs;
    logic [11:0] frame;  // bit i = i-th transmitted bit, start bit first
    int          nbits;
    int          period;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a frame and wait (bounded) for it to be accepted.
  task automatic accept(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                        input logic [2:0] bs, input bit hold);
    int n;
    n = 0;
    tx_data = d;
    parity_mode = pm;
    stop2 = s2;
    baud_set = bs;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_ready", tx_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; checks every cycle of each bit.
  task automatic check_frame(input logic [11:0] exp, input int nbits, input int period,
                             input bit full, input string name);
    for (int i = 0; i < nbits; i++) begin
      int errs;
      errs = 0;
      for (int t = 0; t < period; t++) begin
        if (rs232_tx !== exp[i] || uart_state !== 1'b1 || tx_done !== 1'b0 ||
            tx_ready !== 1'b0) errs++;
        @(posedge clk);
        #1;
      end
      chk($sformatf("%s bit%0d bad_cycles", name, i), errs, 0);
    end
    if (full) begin
      chk({name, " tx_done"}, tx_done, 1);
      chk({name, " uart_state"}, uart_state, 0);
      chk({name, " tx_ready"}, tx_ready, 1);
      chk({name, " line_idle"}, rs232_tx, 1);
    end
  endtask

  initial begin
    int errs;
    vecs[0] = '{8'hA5, 2'b00, 1'b0, 3'd4, 12'h34A, 10, 434};
    vecs[1] = '{8'h07, 2'b10, 1'b0, 3'd4, 12'h60E, 11, 434};
    vecs[2] = '{8'h07, 2'b01, 1'b1, 3'd4, 12'hC0E, 12, 434};
    vecs[3] = '{8'h3C, 2'b11, 1'b1, 3'd4, 12'h678, 11, 434};
    vecs[4] = '{8'hC3, 2'b10, 1'b0, 3'd4, 12'h586, 11, 434};

    @(posedge clk);
    #1;
    chk("reset rs232_tx", rs232_tx, 1);
    chk("reset tx_done", tx_done, 0);
    chk("reset uart_state", uart_state, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    errs = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1;
      if (rs232_tx !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0 ||
          uart_state !== 1'b0) errs++;
    end
    chk("idle bad_cycles", errs, 0);

    for (int v = 0; v < 5; v++) begin
      accept(vecs[v].data, vecs[v].pm, vecs[v].s2, vecs[v].bs, 1'b0);
      check_frame(vecs[v].frame, vecs[v].nbits, vecs[v].period, 1'b1,
                  $sformatf("vec%0d", v));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d done_pulse_end", v), tx_done, 0);
    end

    // Back-to-back with tx_valid held high throughout.
    accept(8'h01, 2'b00, 1'b0, 3'd4, 1'b1);
    check_frame(12'h202, 10, 434, 1'b1, "b2b0");
    accept(8'h02, 2'b00, 1'b0, 3'd4, 1'b1);
    check_frame(12'h204, 10, 434, 1'b1, "b2b1");
    accept(8'h03, 2'b00, 1'b0, 3'd4, 1'b0);
    check_frame(12'h206, 10, 434, 1'b1, "b2b2");
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (rs232_tx !== 1'b1 || tx_done !== 1'b0 || uart_state !== 1'b0) errs++;
    end
    chk("b2b no_extra_frame", errs, 0);

    // Inputs change mid-frame; only the next frame sees them.
    accept(8'h5A, 2'b00, 1'b0, 3'd4, 1'b0);
    tx_data = 8'hFF;
    baud_set = 3'd0;
    parity_mode = 2'b10;
    stop2 = 1'b1;
    check_frame(12'h2B4, 10, 434, 1'b1, "midchg");
    accept(8'h81, 2'b00, 1'b0, 3'd0, 1'b0);
    check_frame(12'h302, 2, 5208, 1'b0, "slow");

    // Now in data bit 1 (line low): reset mid-frame.
    repeat (100) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst line_high", rs232_tx, 1);
    chk("midrst uart_state", uart_state, 0);
    chk("midrst tx_done", tx_done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (rs232_tx !== 1'b1 || tx_done !== 1'b0 || tx_ready !== 1'b1) errs++;
    end
    chk("postrst quiet", errs, 0);
    accept(8'h3C, 2'b00, 1'b0, 3'd4, 1'b0);
    check_frame(12'h278, 10, 434, 1'b1, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter and next-generation byte sender for the serial subsystem.
- Configurable data width; runtime-selectable parity, stop-bit count and baud rate.
- Valid/ready input handshake, so upstream logic (FIFO, command sequencer) can stream frames back-to-back.
- Drives the RS-232 TX line directly, LSB first.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- DIV_W, 16, width of the bit-period counter; must hold the largest table entry.

Ports:
- clk  input  1  system clock, 50 MHz nominal.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_W  frame payload, sampled on accept.
- tx_valid  input  1  upstream has a frame.
- tx_ready  output  1  block can accept a frame this cycle.
- baud_set  input  3  baud select, sampled on accept.
- parity_mode  input  2  00 none, 01 odd, 10 even, 11 none; sampled on accept.
- stop2  input  1  1 = two stop bits, 0 = one; sampled on accept.
- rs232_tx  output  1  serial line, registered, idle high.
- tx_done  output  1  one-cycle pulse after a frame's final stop bit.
- uart_state  output  1  1 while a frame is in flight (state != IDLE).

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: rs232_tx=1, tx_done=0, uart_state=0, state=IDLE, all counters 0. tx_ready=1 once reset is released.
- Accept rule: tx_ready = (state==IDLE), combinational from state. A frame is accepted when tx_valid && tx_ready at a clk edge.
- Captured on accept: tx_data, parity_mode, stop2, and bit period from baud_set. Changes to these inputs mid-frame have no effect.
- Baud table (clocks per bit): 0→5208, 1→2604, 2→1302, 3→868, 4→434. Codes 5..7→5208.
- State machine: IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when the latched mode is none.
  - STOP lasts one or two bit periods.
- Line timing: rs232_tx goes low for the start bit on the first clock after accept. Each bit is held exactly one latched period.
- Bit timer: runs 0..period-1. The state/bit index advances when timer==period-1, and the timer then wraps to 0.
- Data bits: LSB first. The data index counts 0..DATA_W-1.
- Parity bit: even mode = XOR of the data bits; odd mode = inverted XOR. Computed from the latched data.
- Frame length: 1 + DATA_W + (parity?1:0) + (stop2?2:1) bit periods.
- End of frame: on the clock the last stop period ends, state→IDLE. tx_done=1 in the following cycle, which is also the first cycle with tx_ready=1.
  - If tx_valid is high then, the next start bit begins one clock later.
  - Minimum gap between frames is therefore 1 clock plus the stop bits.
- uart_state: 1 from the cycle after accept through the final stop cycle; it deasserts the same cycle tx_done rises.
- Reset mid-frame: the line returns high immediately (asynchronously), nothing is retransmitted and tx_done is not pulsed.
- tx_valid while busy: ignored; no data is lost, because ready is low.

Optional Feature:
- Macro UART_TX_BREAK_EN.
- When defined:
  - Adds input port send_break.
  - send_break high in IDLE holds rs232_tx low and tx_ready low for as long as it is asserted.
  - On release the line returns high, and tx_ready returns one clock later.
  - send_break during a frame is ignored until IDLE.
- When undefined: no port is added and the line is never forced low outside the start and data/parity bits.

Decomposition:
- Package uart_pkg holds:
  - baud divisor constants (BAUD_9600..BAUD_115200);
  - parity_mode encodings;
  - the TX state enum (IDLE, START, DATA, PARITY, STOP), shared with the future receiver.
- Sub-module uart_baud_tick: bit-period counter.
  - Inputs: enable, latched period.
  - Output: one-cycle end-of-bit strobe.
  - Counter restarts when enable is low.

Test Plan:
- Reset release, no tx_valid: rs232_tx=1, tx_ready=1, tx_done=0, uart_state=0 for 20000 clocks.
- baud_set=4, parity none, stop2=0, tx_data=8'hA5: line holds 0 for 434 clocks, then 1,0,1,0,0,1,0,1 at 434 clocks each, then 1 for 434 clocks. tx_done pulses once, 4340 clocks after the start-bit edge.
- parity_mode=10 with tx_data=8'h07 → parity bit 1; parity_mode=01 with tx_data=8'h07 → parity bit 0. Stop2=1 gives a 2×434-clock high tail; total frame 12 bits.
- tx_valid held high, three frames 8'h01/8'h02/8'h03 at baud_set=4:
  - each frame accepted only when tx_ready=1;
  - the start edge of each next frame comes exactly 1 clock after its tx_done;
  - no frame lost or duplicated.
- Change baud_set 4→0 and tx_data mid-frame: the current frame keeps 434-clock bits and the original data; the next accepted frame uses 5208-clock bits.
- Assert rst_n=0 during the DATA state: rs232_tx=1 asynchronously, no tx_done. After release, a new frame of 8'h3C transmits correctly.
